lut_neuron_cfg_writer: RTL and testbench

- Runtime-programmable LogicNets neuron LUT: the write side of a fixed truth-table neuron.
- Accepts a serial stream of truth-table words over a valid/ready config port.
- Stores the table as a 2^IN_BITS x OUT_BITS distributed RAM.
- Once the table is loaded, serves registered inference lookups, so one netlist can take retrained tables without resynthesis.

---
 rtl/lut_neuron_cfg_writer_if.sv | 30 +++
 rtl/lut_neuron_cfg_writer.sv | 111 +++++++++++
 tb/tb_lut_neuron_cfg_writer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_neuron_cfg_writer_if.sv
// Config and inference bus for the runtime-programmable LUT neuron.
// The master drives config beats and lookup requests; the slave is the neuron.
interface lut_neuron_cfg_writer_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
);
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_last;
    logic                busy;
    logic                done;
    logic                err;
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;

    modport master (
        output cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_data,
        input  cfg_ready, busy, done, err, out_valid, out_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_data,
        output cfg_ready, busy, done, err, out_valid, out_data
    );
endinterface

// File: rtl/lut_neuron_cfg_writer.sv
// LogicNets neuron truth table loaded from a serial beat stream, then used for
// registered lookups. Define LUT_CFG_CHECKSUM_EN to require a trailing XOR beat.
module lut_neuron_cfg_writer #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lut_neuron_cfg_writer_if.slave bus
);
    localparam int D     = 1 << IN_BITS;
    localparam int NB    = D * OUT_BITS / CFG_W;
    localparam int CNT_W = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [D*OUT_BITS-1:0] table_q;
    logic                 done_q, err_q, out_valid_q;
    logic [OUT_BITS-1:0]  out_data_q;
    logic                 accept, table_we, load_ok, load_bad, lookup;
`ifdef LUT_CFG_CHECKSUM_EN
    logic [CFG_W-1:0]     csum_q;
`endif

    // A start pulse always wins over a beat offered in the same cycle.
    always_comb begin
        accept = (state == LOAD) && bus.cfg_valid && !bus.cfg_start;
`ifdef LUT_CFG_CHECKSUM_EN
        table_we = accept && (cnt != CNT_W'(NB));
        load_ok  = accept && (cnt == CNT_W'(NB)) && bus.cfg_last
                   && (bus.cfg_data == csum_q);
        load_bad = accept && ((cnt == CNT_W'(NB))
                   ? !(bus.cfg_last && (bus.cfg_data == csum_q))
                   : bus.cfg_last);
`else
        table_we = accept;
        load_ok  = accept && (cnt == CNT_W'(NB - 1)) && bus.cfg_last;
        load_bad = accept && ((cnt == CNT_W'(NB - 1)) != bus.cfg_last);
`endif
        lookup = (state == ACTIVE) && bus.in_valid && !bus.cfg_start;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACTIVE: if (bus.cfg_start) state_nxt = LOAD;
            LOAD: begin
                if (load_ok)       state_nxt = ACTIVE;
                else if (load_bad) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cfg_ready = (state == LOAD);
        bus.busy      = (state == LOAD);
        bus.done      = done_q;
        bus.err       = err_q;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            done_q      <= load_ok;
            out_valid_q <= lookup;
            out_data_q  <= lookup ? table_q[bus.in_data*OUT_BITS +: OUT_BITS] : '0;
            if (bus.cfg_start) begin
                cnt   <= '0;
                err_q <= 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
                csum_q <= '0;
`endif
            end else if (load_ok || load_bad) begin
                cnt <= '0;
                if (load_bad) err_q <= 1'b1;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
`ifdef LUT_CFG_CHECKSUM_EN
                csum_q <= csum_q ^ bus.cfg_data;
`endif
            end
        end
    end

    // Table storage is deliberately left out of reset so it maps to LUT RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (rst_n && table_we && (cnt == CNT_W'(k)))
                table_q[k*CFG_W +: CFG_W] <= bus.cfg_data;
        end
    end
endmodule

// File: tb/tb_lut_neuron_cfg_writer.sv
// Self-checking bench for lut_neuron_cfg_writer: table vectors, directed
// framing cases and random lookups against a flat-array truth-table model.
module tb_lut_neuron_cfg_writer;
    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 1;
    localparam int CFG_W    = 8;
    localparam int D        = 1 << IN_BITS;
    localparam int NB       = D * OUT_BITS / CFG_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lut_neuron_cfg_writer_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) bus();

    lut_neuron_cfg_writer #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ev;
        logic       ed;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit model_tbl [D];
    bit model_active = 1'b0;
    logic [CFG_W-1:0] beatq [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic valid, input logic last,
                                 input logic [CFG_W-1:0] data, input logic iv,
                                 input logic [IN_BITS-1:0] id);
        bus.cfg_start = start;
        bus.cfg_valid = valid;
        bus.cfg_last  = last;
        bus.cfg_data  = data;
        bus.in_valid  = iv;
        bus.in_data   = id;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic startLoad(input logic with_valid);
        applyStimulus(1'b1, with_valid, 1'b0, 8'hA5, 1'b0, '0);
        model_active = 1'b0;
    endtask

    // kind 0: entry = address bit 4, kind 1: all ones, kind 2: random
    task automatic buildTable(input int kind);
        logic [CFG_W-1:0] b;
`ifdef LUT_CFG_CHECKSUM_EN
        logic [CFG_W-1:0] x;
        x = '0;
`endif
        beatq.delete();
        for (int k = 0; k < NB; k++) begin
            b = '0;
            for (int j = 0; j < CFG_W; j++) begin
                int a;
                a = k * CFG_W + j;
                case (kind)
                    0:       b[j] = a[4];
                    1:       b[j] = 1'b1;
                    default: b[j] = 1'($urandom_range(0, 1));
                endcase
            end
            beatq.push_back(b);
`ifdef LUT_CFG_CHECKSUM_EN
            x ^= b;
`endif
        end
`ifdef LUT_CFG_CHECKSUM_EN
        beatq.push_back(x);
`endif
    endtask

    task automatic commitModel();
        logic [CFG_W-1:0] b;
        for (int a = 0; a < D; a++) begin
            b = beatq[a / CFG_W];
            model_tbl[a] = b[a % CFG_W];
        end
        model_active = 1'b1;
    endtask

    // Streams beatq with random valid gaps; lastIdx < 0 means no cfg_last.
    task automatic loadBeats(input int lastIdx, output int done_cnt);
        int   i;
        int   budget;
        logic v;
        logic rdy;
        i = 0;
        budget = 0;
        done_cnt = 0;
        while (i < beatq.size() && budget < 2000) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = bus.cfg_ready;
            applyStimulus(1'b0, v, (i == lastIdx), beatq[i], 1'b0, '0);
            if (bus.done) done_cnt++;
            if (v && rdy) begin
                if (i == lastIdx) i = beatq.size();
                else              i++;
            end
            budget++;
        end
        checkOutput("load_beats_sent", i, beatq.size());
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
            if (bus.done) done_cnt++;
        end
    endtask

    task automatic randomLookups(input int n, input bit always_valid);
        logic             iv;
        logic [IN_BITS-1:0] id;
        for (int k = 0; k < n; k++) begin
            iv = always_valid ? 1'b1 : 1'($urandom_range(0, 1));
            id = IN_BITS'($urandom);
            applyStimulus(1'b0, 1'b0, 1'b0, '0, iv, id);
            checkOutput("rand_out_valid", bus.out_valid, model_active && iv);
            checkOutput("rand_out_data", bus.out_data,
                        (model_active && iv) ? model_tbl[id] : 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   dc;

        vecs[0] = '{1'b1, 8'h10, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'hFF, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h10, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'hEF, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h30, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 8'h2F, 1'b1, 1'b0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h10);
        checkOutput("reset_out_valid", bus.out_valid, 1'b0);
        checkOutput("reset_out_data", bus.out_data, 1'b0);
        checkOutput("reset_cfg_ready", bus.cfg_ready, 1'b0);
        checkOutput("reset_err", bus.err, 1'b0);
        checkOutput("reset_busy", bus.busy, 1'b0);

        $display("[TB] full load, table[a] = a[4]");
        buildTable(0);
        startLoad(1'b1);
        checkOutput("load_busy", bus.busy, 1'b1);
        checkOutput("load_cfg_ready", bus.cfg_ready, 1'b1);
        loadBeats(beatq.size() - 1, dc);
        checkOutput("load_done_pulses", dc, 1);
        checkOutput("load_err", bus.err, 1'b0);
        checkOutput("load_busy_after", bus.busy, 1'b0);
        commitModel();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, vecs[k].iv, vecs[k].id);
            checkOutput("vec_out_valid", bus.out_valid, vecs[k].ev);
            checkOutput("vec_out_data", bus.out_data, vecs[k].ed);
        end
        randomLookups(60, 1'b1);
        randomLookups(60, 1'b0);

        $display("[TB] start while active drops the request");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'h10);
        model_active = 1'b0;
        checkOutput("start_drop_out_valid", bus.out_valid, 1'b0);

        $display("[TB] early last on beat 5");
        buildTable(2);
        loadBeats(5, dc);
        checkOutput("early_done", dc, 0);
        checkOutput("early_err", bus.err, 1'b1);
        checkOutput("early_cfg_ready", bus.cfg_ready, 1'b0);
        checkOutput("early_busy", bus.busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h10);
        checkOutput("early_out_valid", bus.out_valid, 1'b0);
        startLoad(1'b0);
        checkOutput("start_clears_err", bus.err, 1'b0);

        $display("[TB] missing last");
        buildTable(2);
        loadBeats(-1, dc);
        checkOutput("missing_done", dc, 0);
        checkOutput("missing_err", bus.err, 1'b1);
        checkOutput("missing_busy", bus.busy, 1'b0);

        $display("[TB] restart at beat 12, then all-ones load");
        startLoad(1'b0);
        buildTable(2);
        while (beatq.size() > 12) void'(beatq.pop_back());
        loadBeats(-1, dc);
        checkOutput("restart_partial_busy", bus.busy, 1'b1);
        startLoad(1'b0);
        buildTable(1);
        loadBeats(beatq.size() - 1, dc);
        checkOutput("restart_done", dc, 1);
        commitModel();
        randomLookups(40, 1'b1);

        $display("[TB] reset at beat 20");
        startLoad(1'b0);
        buildTable(2);
        while (beatq.size() > 20) void'(beatq.pop_back());
        loadBeats(-1, dc);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        rst_n = 1'b1;
        model_active = 1'b0;
        checkOutput("midreset_busy", bus.busy, 1'b0);
        checkOutput("midreset_cfg_ready", bus.cfg_ready, 1'b0);
        checkOutput("midreset_done", bus.done, 1'b0);
        checkOutput("midreset_err", bus.err, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h10);
        checkOutput("midreset_out_valid", bus.out_valid, 1'b0);

        $display("[TB] random table load and random lookups");
        startLoad(1'b0);
        buildTable(2);
        loadBeats(beatq.size() - 1, dc);
        checkOutput("random_done", dc, 1);
        commitModel();
        randomLookups(150, 1'b0);

`ifdef LUT_CFG_CHECKSUM_EN
        $display("[TB] checksum beat with bit 0 flipped");
        startLoad(1'b0);
        buildTable(2);
        beatq[NB] = beatq[NB] ^ 8'h01;
        loadBeats(NB, dc);
        checkOutput("csum_bad_done", dc, 0);
        checkOutput("csum_bad_err", bus.err, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h10);
        checkOutput("csum_bad_out_valid", bus.out_valid, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
